// File: rtl/jt12_wr_sched.sv
// Queues {part,reg,data} writes and replays them to jt12_top as an addr then a data strobe, then waits out busy. A push into an empty FIFO strobes on the next cen edge; req_ready drops when full.
// `JT12_WR_TIMEOUT_EN adds a bounded busy wait (BUSY_TIMEOUT) with a sticky timeout flag.
module jt12_wr_sched #(
  parameter int DEPTH_LOG2   = 4,
  parameter int MIN_GAP      = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_part,
  input  logic [7:0]            req_reg,
  input  logic [7:0]            req_data,
  output logic [1:0]            fm_addr,
  output logic [7:0]            fm_din,
  output logic                  fm_cs_n,
  output logic                  fm_wr_n,
  input  logic [7:0]            fm_dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle,
  output logic                  timeout
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = (MIN_GAP > 0) ? GW'(MIN_GAP - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_GAP, S_POLL} state_t;
  state_t state, state_nx;

  logic [16:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [16:0]           head;
  logic [DEPTH_LOG2:0]   level_nx;
  logic                  push, pop, busy, poll_expire;
  logic                  h_part;
  logic [7:0]            h_data;
  logic [GW-1:0]         gap_cnt;
  logic                  unused_dout;

  assign req_ready   = (level != FULL);
  assign push        = req_valid & req_ready;
  assign busy        = fm_dout[7];
  assign head        = mem[rd_ptr];
  assign unused_dout = ^fm_dout[6:0];
  assign level_nx    = flush ? '0 :
                       level + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};

  // Leaving POLL with work queued pops straight into ADDR, skipping IDLE.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    if (cen) begin
      case (state)
        S_IDLE: if (level != '0) begin
          state_nx = S_ADDR;
          pop      = 1'b1;
        end
        S_ADDR: state_nx = S_DATA;
        S_DATA: state_nx = S_GAP;
        S_GAP:  if (gap_cnt == GAP_LAST) state_nx = S_POLL;
        S_POLL: if (poll_expire) begin
          state_nx = S_IDLE;
        end else if (!busy) begin
          if (level != '0) begin
            state_nx = S_ADDR;
            pop      = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_part, req_reg, req_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      idle    <= 1'b1;
      gap_cnt <= '0;
      h_part  <= 1'b0;
      h_data  <= '0;
      fm_addr <= '0;
      fm_din  <= '0;
      fm_cs_n <= 1'b1;
      fm_wr_n <= 1'b1;
    end else begin
      state <= state_nx;
      level <= level_nx;
      idle  <= (level_nx == '0) && (state_nx == S_IDLE);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) begin
        h_part <= head[16];
        h_data <= head[7:0];
      end
      // Outputs only move on cen edges so a strobe holds through cen=0 stretches.
      if (cen) begin
        gap_cnt <= (state == S_GAP && state_nx == S_GAP) ? gap_cnt + 1'b1 : '0;
        fm_cs_n <= 1'b1;
        fm_wr_n <= 1'b1;
        case (state_nx)
          S_ADDR: begin
            fm_addr <= {head[16], 1'b0};
            fm_din  <= head[15:8];
            fm_cs_n <= 1'b0;
            fm_wr_n <= 1'b0;
          end
          S_DATA: begin
            fm_addr <= {h_part, 1'b1};
            fm_din  <= h_data;
            fm_cs_n <= 1'b0;
            fm_wr_n <= 1'b0;
          end
          S_GAP, S_POLL: fm_addr <= {h_part, 1'b0};
          default: ;
        endcase
      end
    end
  end

`ifdef JT12_WR_TIMEOUT_EN
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  logic [TW-1:0] poll_cnt;

  assign poll_expire = (state == S_POLL) && busy && (poll_cnt == TW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= '0;
      timeout  <= 1'b0;
    end else if (cen) begin
      poll_cnt <= (state == S_POLL && state_nx == S_POLL) ? poll_cnt + 1'b1 : '0;
      if (poll_expire) timeout <= 1'b1;
    end
  end
`else
  localparam int unused_busy_timeout = BUSY_TIMEOUT;
  assign poll_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule
